// File: rtl/store_data_port_arbiter_pkg.sv
// Shared store-data lookup types: sequence numbers, the lookup uop, the branch
// provider bundle and wrap-aware age helpers.
// Optional build macro used by the arbiter top: STDATA_ARB_SKID_EN.
package store_data_port_arbiter_pkg;

  localparam int SQN_W  = 6;
  localparam int TAG_W  = 7;
  localparam int OFFS_W = 4;

  // Largest number of store-data issue queues one arbiter instance supports.
  localparam int STDATA_ARB_MAX_REQ = 4;

  typedef logic [SQN_W-1:0] SqN;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    SqN                storeSqN;
    logic [OFFS_W-1:0] offs;
  } StDataLookupUOp;

  typedef struct packed {
    logic taken;
    logic flush;
    SqN   storeSqN;
  } BranchProv;

  // a is strictly older than b: $signed(a - b) < 0, modular in SQN_W.
  function automatic logic sqn_older(input SqN a, input SqN b);
    SqN diff;
    diff = a - b;
    return diff[SQN_W-1];
  endfunction

  // a is strictly younger than b: $signed(a - b) > 0, modular in SQN_W.
  function automatic logic sqn_younger(input SqN a, input SqN b);
    SqN diff;
    diff = a - b;
    return (diff != '0) && !diff[SQN_W-1];
  endfunction

endpackage

// File: rtl/store_data_port_arbiter_age_select.sv
// sqn_age_select: combinational oldest-valid selector over NUM_REQ candidates.
// Ages compare wrap-aware on storeSqN; equal sequence numbers resolve to the
// lowest index. Kept generic so load-side arbiters can reuse it.
module sqn_age_select
  import store_data_port_arbiter_pkg::*;
#(
  parameter int  NUM_REQ = 2,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] valid,
  input  SqN                 sqn [NUM_REQ],
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  SqN best_sqn;

  // Scan low to high, replacing the current pick only when strictly older so
  // that ties stay with the lower index.
  always_comb begin
    idx      = '0;
    any      = 1'b0;
    best_sqn = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (valid[i] && (!any || sqn_older(sqn[i], best_sqn))) begin
        idx      = IDX_W'(i);
        any      = 1'b1;
        best_sqn = sqn[i];
      end
    end
  end

endmodule

// File: rtl/store_data_port_arbiter.sv
// store_data_port_arbiter: shares the single store-data register-file read
// port between NUM_REQ store-data issue queues. The oldest valid candidate is
// granted into a registered lookup stage; wrong-path uops are squashed on
// branch mispredicts and the stage holds while the consumer stalls.
// Optional build macro: STDATA_ARB_SKID_EN adds a one-entry skid buffer so the
// grant no longer depends combinationally on IN_ready.
//
// Handshakes: an issue queue's uop i transfers when IN_uop[i].valid &&
// OUT_ready[i]; the lookup stage transfers downstream when OUT_uop.valid &&
// IN_ready. A transfer is final once both sides see it in the same cycle,
// even if a branch squashes the entry at that edge.
module store_data_port_arbiter
  import store_data_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  StDataLookupUOp     IN_uop [NUM_REQ],
  output logic [NUM_REQ-1:0] OUT_ready,
  input  BranchProv          IN_branch,
  input  logic               IN_ready,
  output StDataLookupUOp     OUT_uop,
  output logic               OUT_idle
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] req_valid;
  SqN                 req_sqn [NUM_REQ];
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_any;
  StDataLookupUOp     win_uop;
  logic               grant;
  logic               out_squash;

  // Split the candidate bundles into the fields the age selector needs.
  always_comb begin
    req_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i] = IN_uop[i].valid;
      req_sqn[i]   = IN_uop[i].storeSqN;
    end
  end

  sqn_age_select #(
    .NUM_REQ (NUM_REQ)
  ) u_age_select (
    .valid (req_valid),
    .sqn   (req_sqn),
    .idx   (sel_idx),
    .any   (sel_any)
  );

  assign win_uop = IN_uop[sel_idx];

  // A held entry dies on a taken branch when flushing or strictly younger
  // than the branch; an equal sequence number is the branch itself and stays.
  function automatic logic squash_hit(input StDataLookupUOp uop, input BranchProv br);
    return uop.valid && br.taken && (br.flush || sqn_younger(uop.storeSqN, br.storeSqN));
  endfunction

  assign out_squash = squash_hit(OUT_uop, IN_branch);

  // Only the winner ever sees ready; reset forces every grant low.
  always_comb begin
    OUT_ready = '0;
    if (grant) begin
      OUT_ready[sel_idx] = 1'b1;
    end
  end

`ifdef STDATA_ARB_SKID_EN

  StDataLookupUOp skid_q;
  logic           skid_squash;
  logic           out_keep;
  logic           skid_keep;

  assign skid_squash = squash_hit(skid_q, IN_branch);

  // Grant depends on registered state only: a free skid slot always has
  // room for one more uop regardless of what the consumer does this cycle.
  assign grant = rst && sel_any && !skid_q.valid && !IN_branch.taken;

  // OUT_uop survives the edge if it is neither consumed nor squashed.
  assign out_keep  = OUT_uop.valid && !IN_ready && !out_squash;
  assign skid_keep = skid_q.valid && !skid_squash;

  // Output stage plus skid: the skid is always older than a fresh grant, so
  // it refills OUT_uop first and a same-cycle grant lands behind it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      OUT_uop.valid <= 1'b0;
      skid_q.valid  <= 1'b0;
    end else if (out_keep) begin
      if (!skid_keep) begin
        if (grant) begin
          skid_q <= win_uop;
        end else begin
          skid_q.valid <= 1'b0;
        end
      end
    end else if (skid_keep) begin
      // A valid skid blocks granting, so the skid simply empties here.
      OUT_uop      <= skid_q;
      skid_q.valid <= 1'b0;
    end else begin
      if (grant) begin
        OUT_uop <= win_uop;
      end else begin
        OUT_uop.valid <= 1'b0;
      end
      skid_q.valid <= 1'b0;
    end
  end

  assign OUT_idle = !OUT_uop.valid && !skid_q.valid;

`else

  logic load_en;

  // The stage can take a new uop when it is empty or being drained now.
  assign load_en = !OUT_uop.valid || IN_ready;
  assign grant   = rst && sel_any && load_en && !IN_branch.taken;

  // Output stage: load the winner, drain to empty, or hold under backpressure
  // unless a branch kills the held entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      OUT_uop.valid <= 1'b0;
    end else if (load_en) begin
      if (grant) begin
        OUT_uop <= win_uop;
      end else begin
        OUT_uop.valid <= 1'b0;
      end
    end else if (out_squash) begin
      OUT_uop.valid <= 1'b0;
    end
  end

  assign OUT_idle = !OUT_uop.valid;

`endif

endmodule

// File: tb/tb_store_data_port_arbiter.sv
// Bench for store_data_port_arbiter (default build or STDATA_ARB_SKID_EN).
// Stimulus: directed reset/age/wrap/backpressure/branch cases followed by a
// randomized streaming phase. The reference model keeps issue queues and the
// arbiter's held uops as plain queues; expected per-cycle status and expected
// downstream transfers are pushed into queues and popped by a monitor.
module tb_store_data_port_arbiter;
  import store_data_port_arbiter_pkg::*;

  localparam int N  = 2;
  localparam int UW = $bits(StDataLookupUOp);
`ifdef STDATA_ARB_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  typedef struct packed {
    logic         rst_v;
    logic         known;
    logic [N-1:0] rdy;
    logic         vld;
  } status_t;

  // clock / reset / DUT
  logic           clk = 1'b0;
  logic           rst;
  StDataLookupUOp in_uop [N];
  logic [N-1:0]   out_ready;
  BranchProv      in_branch;
  logic           in_ready;
  StDataLookupUOp out_uop;
  logic           out_idle;

  always #5 clk = ~clk;

  store_data_port_arbiter #(.NUM_REQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .IN_uop    (in_uop),
    .OUT_ready (out_ready),
    .IN_branch (in_branch),
    .IN_ready  (in_ready),
    .OUT_uop   (out_uop),
    .OUT_idle  (out_idle)
  );

  // reference model state
  StDataLookupUOp iq [N][$];
  StDataLookupUOp pipe [$];
  logic           known = 1'b0;
  SqN             next_sqn;
  int             pushed_n = 0;
  int             seen_n = 0;

  // scoreboard
  logic [UW-1:0]  exp_q [$];
  status_t        st_q [$];
  int             checks = 0;
  int             errors = 0;

  function automatic StDataLookupUOp mk(input SqN s);
    StDataLookupUOp u;
    u.valid    = 1'b1;
    u.tag      = TAG_W'($urandom);
    u.storeSqN = s;
    u.offs     = OFFS_W'($urandom);
    return u;
  endfunction

  function automatic logic younger(input SqN a, input SqN b);
    SqN d;
    d = a - b;
    return $signed(d) > 0;
  endfunction

  // Oldest issue-queue head by modular age; ties go to the lower index.
  function automatic int oldest();
    int best;
    SqN d;
    best = -1;
    for (int i = 0; i < N; i++) begin
      if (iq[i].size() > 0) begin
        if (best < 0) begin
          best = i;
        end else begin
          d = iq[i][0].storeSqN - iq[best][0].storeSqN;
          if ($signed(d) < 0) best = i;
        end
      end
    end
    return best;
  endfunction

  task automatic squash_all(input logic fl, input SqN bs);
    StDataLookupUOp keep [$];
    keep = {};
    for (int j = 0; j < pipe.size(); j++)
      if (!(fl || younger(pipe[j].storeSqN, bs))) keep.push_back(pipe[j]);
    pipe = keep;
    for (int i = 0; i < N; i++) begin
      keep = {};
      for (int j = 0; j < iq[i].size(); j++)
        if (!(fl || younger(iq[i][j].storeSqN, bs))) keep.push_back(iq[i][j]);
      iq[i] = keep;
    end
  endtask

  // driver: one clock cycle of stimulus plus the model's prediction for it
  task automatic step(input logic r, input logic rdy, input logic tk, input logic fl, input SqN bs);
    int      win;
    status_t st;
    @(posedge clk);
    #1;
    rst       = r;
    in_ready  = rdy;
    in_branch = '{taken: tk, flush: fl, storeSqN: bs};
    for (int i = 0; i < N; i++) in_uop[i] = (iq[i].size() > 0) ? iq[i][0] : '0;
    win = -1;
    if (r && !tk && ((CAP == 1) ? (pipe.size() == 0 || rdy) : (pipe.size() < CAP)))
      win = oldest();
    st.rst_v = r;
    st.known = known;
    st.rdy   = '0;
    if (win >= 0) st.rdy[win] = 1'b1;
    st.vld = (pipe.size() > 0);
    st_q.push_back(st);
    if (r && rdy && pipe.size() > 0) begin
      exp_q.push_back(pipe.pop_front());
      pushed_n++;
    end
    if (!r) begin
      pipe.delete();
      known = 1'b1;
    end
    if (tk) squash_all(fl, bs);
    if (win >= 0) pipe.push_back(iq[win].pop_front());
  endtask

  // monitor: pops expectations whenever a cycle's status or a transfer shows up
  initial begin
    status_t       st;
    logic [UW-1:0] e;
    forever begin
      @(negedge clk);
      if (st_q.size() > 0) begin
        st = st_q.pop_front();
        checks++;
        if (out_ready !== st.rdy) begin
          errors++;
          $display("FAIL out_ready t=%0t actual=%b required=%b", $time, out_ready, st.rdy);
        end
        if (st.known) begin
          checks++;
          if (out_uop.valid !== st.vld) begin
            errors++;
            $display("FAIL out_valid t=%0t actual=%b required=%b", $time, out_uop.valid, st.vld);
          end
          checks++;
          if (out_idle !== !st.vld) begin
            errors++;
            $display("FAIL out_idle t=%0t actual=%b required=%b", $time, out_idle, !st.vld);
          end
        end
        if (st.rst_v && out_uop.valid === 1'b1 && in_ready === 1'b1) begin
          seen_n++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL transfer t=%0t actual=%h required=none", $time, out_uop);
          end else begin
            e = exp_q.pop_front();
            if (UW'(out_uop) !== e) begin
              errors++;
              $display("FAIL transfer t=%0t actual=%h required=%h", $time, out_uop, e);
            end
          end
        end
      end
    end
  end

  // stimulus
  initial begin
    rst       = 1'b0;
    in_ready  = 1'b0;
    in_branch = '0;
    for (int i = 0; i < N; i++) in_uop[i] = '0;

    // reset with every requester valid: no grant, empty stage
    iq[0].push_back(mk(6'd10));
    iq[1].push_back(mk(6'd11));
    repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < N; i++) iq[i].delete();

    // age: 3 beats 5
    iq[0].push_back(mk(6'd5));
    iq[1].push_back(mk(6'd3));
    repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0, '0);

    // wrap: 62 is older than 1
    iq[0].push_back(mk(6'd62));
    iq[1].push_back(mk(6'd1));
    repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0, '0);

    // backpressure: hold four cycles, then drain with nothing lost
    iq[0].push_back(mk(6'd20));
    iq[0].push_back(mk(6'd22));
    iq[1].push_back(mk(6'd21));
    step(1'b1, 1'b1, 1'b0, 1'b0, '0);
    repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    repeat (4) step(1'b1, 1'b1, 1'b0, 1'b0, '0);

    // branch older than held uop squashes it
    iq[0].push_back(mk(6'd9));
    step(1'b1, 1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 6'd7);
    step(1'b1, 1'b1, 1'b0, 1'b0, '0);
    // branch equal to held uop keeps it; an older waiting request is not granted that cycle
    iq[0].push_back(mk(6'd7));
    step(1'b1, 1'b1, 1'b0, 1'b0, '0);
    iq[1].push_back(mk(6'd4));
    step(1'b1, 1'b0, 1'b1, 1'b0, 6'd7);
    repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0, '0);
    // flush clears regardless of age
    iq[0].push_back(mk(6'd8));
    step(1'b1, 1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 6'd8);
    step(1'b1, 1'b1, 1'b0, 1'b0, '0);
    // consume and squash in the same cycle: transfer still counts
    iq[0].push_back(mk(6'd12));
    step(1'b1, 1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 6'd11);
    step(1'b1, 1'b1, 1'b0, 1'b0, '0);

    // reset mid-transfer drops the held uop
    iq[0].push_back(mk(6'd30));
    step(1'b1, 1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, 1'b0, '0);
    repeat (2) step(1'b1, 1'b1, 1'b0, 1'b0, '0);

    // randomized streaming with random backpressure and branches
    next_sqn = 6'd40;
    for (int c = 0; c < 800; c++) begin
      logic tk;
      logic fl;
      SqN   bs;
      for (int i = 0; i < N; i++) begin
        if (iq[i].size() < 3 && $urandom_range(0, 2) != 0) begin
          iq[i].push_back(mk(next_sqn));
          next_sqn = next_sqn + 6'd1;
        end
      end
      tk = ($urandom_range(0, 11) == 0);
      fl = tk && ($urandom_range(0, 3) == 0);
      bs = next_sqn - SqN'($urandom_range(1, 8));
      step(1'b1, 1'($urandom_range(0, 1)), tk, fl, tk ? bs : '0);
    end

    // drain
    repeat (12) step(1'b1, 1'b1, 1'b0, 1'b0, '0);
    @(negedge clk);
    #1;

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover actual=%0d required=0", exp_q.size());
    end
    checks++;
    if (seen_n != pushed_n) begin
      errors++;
      $display("FAIL transfer_count actual=%0d required=%0d", seen_n, pushed_n);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
